aes_key_expansion: RTL and testbench
====================================

// Module: aes_key_expansion
// PURPOSE
//  AES-128 key-schedule unit for the iterative AES_128 datapath.
//  - Expands the 128-bit master key into 11 round keys (rounds 0..10).
//  - Presents the key selected by the controller's round counter on a registered output.
//  - The top level XORs that output into the state matrix in AddRoundKey / I_AddRoundKey.
//  - Contains its own forward S-box (SubWord), the FIPS-197 forward S-box table.
//  - The same key table serves encryption and decryption.
// PARAMETERS
//  none (AES-128 fixed: Nk=4, Nr=10)
// PORTS
//  clk            in   1    rising-edge clock; one clock for the block
//  rst_n          in   1    asynchronous, active-low reset
//  key_in         in   128  master key; byte0 = key_in[127:120]; must be held stable during operation
//  round          in   4    round index 0..10 whose key is requested
//  cnt            in   5    signed controller step counter (-1..15); informational, no functional effect
//  current_state  in   4    controller FSM state; informational, no functional effect
//  inv_en         in   1    1 = decrypt phase; no functional effect (same table both directions)
//  round_key_o    out  128  registered round key for `round`; word w[4r] in [127:96]
// BEHAVIOUR
//  - Word order: w0=key_in[127:96], w1=[95:64], w2=[63:32], w3=[31:0].
//  - Expansion for i=4..43:
//    - temp = w[i-1].
//    - If i%4==0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/4],24'h0}.
//      - RotWord({a,b,c,d}) = {b,c,d,a}; SubWord applies the S-box to each byte.
//    - w[i] = w[i-4] ^ temp.
//  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
//  - Round key r = {w[4r],w[4r+1],w[4r+2],w[4r+3]}; round key 0 = key_in.
//  - Expansion is purely combinational from key_in; no internal key storage.
//  - Output register, updated every rising clk:
//    - round 0..10 -> round_key_o <= key(round).
//    - round 11..15 -> round_key_o <= 128'h0.
//  - Latency: round_key_o reflects `round` (and key_in) sampled at the previous edge; exactly 1 cycle.
//    - The controller's IDLE cycle pre-loads key(0) for encrypt and key(10) for decrypt.
//    - The controller's 7-cycle AddRoundKey window covers this latency after each round change.
//  - Reset: rst_n low -> round_key_o = 128'h0 immediately (async).
//    - Reset deasserts synchronously to clk in the controller.
//    - First edge after release loads key(round).
//  - Reset mid-operation: output clears at once; resumes 1 cycle after release with key(round).
//  - key_in changing mid-run: new schedule appears on the next edge (no latching); the controller must hold key_in.
//  - No X propagation: all 16 round values are decoded; cnt, current_state and inv_en never alter the output.
// TESTING
//  - Reset: rst_n=0, any inputs -> round_key_o==0.
//    - Release with key_in=2b7e151628aed2a6abf7158809cf4f3c, round=0.
//    - After 1 edge round_key_o==2b7e151628aed2a6abf7158809cf4f3c.
//  - FIPS-197 key 2b7e1516...4f3c:
//    - round=1 -> a0fafe1788542cb123a339392a6c7605.
//    - round=2 -> f2c295f27a96b9435935807a7359f67f.
//    - round=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
//  - key_in=0:
//    - round=1 -> 62636363626363636263636362636363.
//    - round=10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
//  - Latency/out-of-range:
//    - Step round 3->4 at edge k: output shows key(3) until edge k+1, then key(4).
//    - round=12 -> 0 after one edge.
//  - Invariance: sweep inv_en 0/1, cnt -1..15, current_state 0..9 with round fixed -> output unchanged.
//  - Async reset mid-sequence: assert rst_n between edges at round=7 -> output 0 with no clock edge.
//    - Release -> key(7) after next edge.

Source files
------------

// File: rtl/aes_key_expansion_if.sv
// ----------------------------------------------------------------------------
// aes_key_expansion_if
//   Bundles the signals between the AES_128 controller and the key-schedule
//   unit.
//   key_in        [127:0]  master key, byte0 = [127:120]
//   round         [3:0]    round index whose key is requested
//   cnt           [4:0]    signed controller step counter (informational)
//   current_state [3:0]    controller FSM state (informational)
//   inv_en                 decrypt phase flag (informational)
//   round_key_o   [127:0]  registered round key
//   master : controller side, slave : key-schedule side
// ----------------------------------------------------------------------------
interface aes_key_expansion_if;
    logic [127:0]      key_in;
    logic [3:0]        round;
    logic signed [4:0] cnt;
    logic [3:0]        current_state;
    logic              inv_en;
    logic [127:0]      round_key_o;

    modport master (
        output key_in, round, cnt, current_state, inv_en,
        input  round_key_o
    );

    modport slave (
        input  key_in, round, cnt, current_state, inv_en,
        output round_key_o
    );
endinterface

// File: rtl/aes_key_expansion.sv
// ----------------------------------------------------------------------------
// aes_key_expansion
//   AES-128 key schedule. Expands key_in combinationally into the 11 round
//   keys and registers the key selected by `round` (zero for rounds 11..15).
//   Output latency is one clock; same table serves encrypt and decrypt.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears round_key_o
//   kx     slave side of aes_key_expansion_if (key_in, round, cnt,
//          current_state, inv_en in; round_key_o out)
// ----------------------------------------------------------------------------
module aes_key_expansion (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_key_expansion_if.slave    kx
);

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box built from its definition (x^254 inverse, then affine
    // map) instead of a 256-entry literal; yields the FIPS-197 table exactly,
    // including S(0)=63 since 0^254 evaluates to 0.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    logic [43:0][31:0]  w;
    logic [15:0][127:0] rk_all;
    logic [31:0]        temp;
    logic [127:0]       round_key_d;
    logic [127:0]       round_key_q;

    // Controller status inputs are informational only.
    logic unused_status;
    assign unused_status = ^{kx.cnt, kx.current_state, kx.inv_en};

    always_comb begin
        w    = '0;
        temp = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w[i] = kx.key_in[32*(3-i) +: 32];
        end
        for (int unsigned i = 4; i < 44; i++) begin
            temp = w[i-1];
            if ((i % 4) == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sbox(temp[31:24]), sbox(temp[23:16]),
                        sbox(temp[15:8]),  sbox(temp[7:0])};
                temp = temp ^ {rcon(4'(i / 4)), 24'h0};
            end
            w[i] = w[i-4] ^ temp;
        end
        // Entries 11..15 stay zero so every round value is decoded.
        rk_all = '0;
        for (int unsigned r = 0; r < 11; r++) begin
            rk_all[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        round_key_d = rk_all[kx.round];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_key_q <= '0;
        end else begin
            round_key_q <= round_key_d;
        end
    end

    assign kx.round_key_o = round_key_q;

endmodule

// File: tb/tb_aes_key_expansion.sv
// ----------------------------------------------------------------------------
// tb_aes_key_expansion
//   Self-checking bench for aes_key_expansion: FIPS-197 vectors, latency,
//   out-of-range rounds, status-input invariance, async reset and random keys
//   against a behavioural key-schedule model.
// ----------------------------------------------------------------------------
module tb_aes_key_expansion;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [7:0] sb_tbl [256];

    aes_key_expansion_if kx_if ();

    aes_key_expansion dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kx    (kx_if.slave)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_mul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] p;
        a = a_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return p;
    endfunction

    // S-box table: inverse found by exhaustive search, then bitwise affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
                       ^ inv[(i+7)%8] ^ c[i];
            end
            sb_tbl[x] = s;
        end
    endtask

    function automatic logic [127:0] ref_key(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc [11];
        rc = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        if (r > 10) return 128'h0;
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_tbl[t[31:24]], sb_tbl[t[23:16]], sb_tbl[t[15:8]], sb_tbl[t[7:0]]};
                t = t ^ {rc[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Drive key/round with random status inputs at the falling edge, then
    // wait for the next rising edge and settle.
    task automatic drive(input logic [127:0] k, input logic [3:0] r);
        @(negedge clk);
        kx_if.key_in        = k;
        kx_if.round         = r;
        kx_if.cnt           = 5'($urandom);
        kx_if.current_state = 4'($urandom_range(0, 9));
        kx_if.inv_en        = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] rk;
        logic [127:0] k;
        logic [3:0]   r;
        n_tests = 0;
        n_fail  = 0;
        clk     = 1'b0;
        rst_n   = 1'b0;
        build_sbox();
        kx_if.key_in        = {$urandom, $urandom, $urandom, $urandom};
        kx_if.round         = 4'($urandom);
        kx_if.cnt           = 5'($urandom);
        kx_if.current_state = 4'($urandom);
        kx_if.inv_en        = 1'($urandom);

        // Reset held across edges
        repeat (3) @(posedge clk);
        #1;
        check("reset", kx_if.round_key_o, 128'h0);

        // Release, first edge loads key(0)
        @(negedge clk);
        kx_if.key_in = FIPS_KEY;
        kx_if.round  = 4'd0;
        rst_n        = 1'b1;
        #1;
        check("release_no_edge", kx_if.round_key_o, 128'h0);
        @(posedge clk);
        #1;
        check("release_key0", kx_if.round_key_o, FIPS_KEY);

        // FIPS-197 vectors (constants) and model agreement
        drive(FIPS_KEY, 4'd1);
        check("fips_r1", kx_if.round_key_o, 128'ha0fafe1788542cb123a339392a6c7605);
        drive(FIPS_KEY, 4'd2);
        check("fips_r2", kx_if.round_key_o, 128'hf2c295f27a96b9435935807a7359f67f);
        drive(FIPS_KEY, 4'd10);
        check("fips_r10", kx_if.round_key_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("model_fips_r10", kx_if.round_key_o, ref_key(FIPS_KEY, 10));

        // Zero key
        drive(128'h0, 4'd1);
        check("zero_r1", kx_if.round_key_o, 128'h62636363626363636263636362636363);
        drive(128'h0, 4'd10);
        check("zero_r10", kx_if.round_key_o, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Latency: round 3 -> 4
        drive(FIPS_KEY, 4'd3);
        check("lat_r3", kx_if.round_key_o, ref_key(FIPS_KEY, 3));
        @(negedge clk);
        kx_if.round = 4'd4;
        #1;
        check("lat_hold_r3", kx_if.round_key_o, ref_key(FIPS_KEY, 3));
        @(posedge clk);
        #1;
        check("lat_r4", kx_if.round_key_o, ref_key(FIPS_KEY, 4));

        // Out-of-range rounds
        for (int i = 11; i < 16; i++) begin
            drive(FIPS_KEY, 4'(i));
            check($sformatf("oob_r%0d", i), kx_if.round_key_o, 128'h0);
        end

        // Status-input invariance with round fixed
        r  = 4'($urandom_range(0, 10));
        rk = ref_key(FIPS_KEY, int'(r));
        for (int c = -1; c <= 15; c++) begin
            for (int s = 0; s <= 9; s++) begin
                for (int e = 0; e < 2; e++) begin
                    @(negedge clk);
                    kx_if.key_in        = FIPS_KEY;
                    kx_if.round         = r;
                    kx_if.cnt           = 5'(c);
                    kx_if.current_state = 4'(s);
                    kx_if.inv_en        = 1'(e);
                    @(posedge clk);
                    #1;
                    check($sformatf("inv_c%0d_s%0d_e%0d", c, s, e), kx_if.round_key_o, rk);
                end
            end
        end

        // Async reset mid-sequence at round 7
        drive(FIPS_KEY, 4'd7);
        check("pre_rst_r7", kx_if.round_key_o, ref_key(FIPS_KEY, 7));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", kx_if.round_key_o, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_hold", kx_if.round_key_o, 128'h0);
        @(posedge clk);
        #1;
        check("rst_resume_r7", kx_if.round_key_o, ref_key(FIPS_KEY, 7));

        // Random keys and rounds, key changing every cycle
        for (int n = 0; n < 60; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            r = 4'($urandom);
            drive(k, r);
            check($sformatf("rand%0d_r%0d", n, r), kx_if.round_key_o, ref_key(k, int'(r)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
